// File: rtl/buzz_tone_gen.sv
// Buzzer square-wave generator: qualifies the requested tone period, plays it at one
// of four duty levels, applies note changes only at period boundaries, and releases.
module buzz_tone_gen #(
  parameter int unsigned CNT_W           = 32,
  parameter int unsigned MIN_PERIOD      = 64,
  parameter int unsigned RELEASE_PERIODS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             modechange,
  input  logic [CNT_W-1:0] frequency,
  input  logic [1:0]       volume,
  output logic             pwm,
  output logic             active,
  output logic             period_done
);

  localparam int unsigned      REL_W    = (RELEASE_PERIODS > 0) ? $clog2(RELEASE_PERIODS + 1) : 1;
  localparam logic [CNT_W-1:0] MIN_P    = CNT_W'(MIN_PERIOD);
  localparam logic [REL_W-1:0] REL_INIT = REL_W'(RELEASE_PERIODS);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    RELEASE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cur_q, cur_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic [REL_W-1:0] rel_q, rel_d;
  logic             pwm_q, pwm_d;

  logic [CNT_W-1:0] req;
  logic [CNT_W-1:0] high_cnt;
  logic             boundary;

  always_comb begin
    req      = (frequency >= MIN_P) ? frequency : '0;
    boundary = (state_q != IDLE) && (cnt_q == (cur_q - CNT_W'(1)));

    high_cnt = '0;
    if (state_q == RELEASE) begin
      if (volume != 2'd0) high_cnt = cur_q >> 3;
    end else begin
      case (volume)
        2'd3:    high_cnt = cur_q >> 1;
        2'd2:    high_cnt = cur_q >> 2;
        2'd1:    high_cnt = cur_q >> 3;
        default: high_cnt = '0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    pend_d  = req;
    rel_d   = rel_q;
    // pwm is derived from the registered counter, so it lags cnt by one cycle
    pwm_d   = (state_q != IDLE) && (cnt_q < high_cnt);

    case (state_q)
      IDLE: begin
        if (req != '0) begin
          cur_d   = req;
          cnt_d   = '0;
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (boundary) begin
          cnt_d = '0;
          if (pend_q != '0) begin
            cur_d = pend_q;
          end else if (RELEASE_PERIODS > 0) begin
            rel_d   = REL_INIT;
            state_d = RELEASE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (boundary) begin
          cnt_d = '0;
          rel_d = rel_q - REL_W'(1);
          if (req != '0) begin
            cur_d   = req;
            state_d = PLAY;
          end else if (rel_q <= REL_W'(1)) begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset || modechange) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cur_q   <= '0;
      pend_q  <= '0;
      rel_q   <= '0;
      pwm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
      rel_q   <= rel_d;
      pwm_q   <= pwm_d;
    end
  end

  assign pwm         = pwm_q;
  assign active      = (state_q != IDLE);
  assign period_done = boundary;

endmodule

// File: doc/buzz_tone_gen.md
Name: buzz_tone_gen

Overview:
- Downstream of the auto/learn music player. Consumes the player's `frequency` word, a tone period in clk cycles where 0 means silence, and drives the buzzer `pwm` pin.
- Generates a glitch-free square wave with four discrete volume levels.
- Note changes take effect only at period boundaries. Short, illegal periods are rejected as silence.
- Exposes status so the player and LED logic can track tone activity.

Parameters:
- CNT_W, 32, width of the period counter and of the `frequency` input.
- MIN_PERIOD, 64, smallest accepted period in clk cycles. A non-zero `frequency` below this is treated as silence.
- RELEASE_PERIODS, 4, number of whole periods the last tone keeps sounding at volume level 1 after `frequency` drops to 0. A value of 0 disables release.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous active-low reset.
- modechange, input, 1, mode switch pulse. Synchronous clear identical to reset.
- frequency, input, CNT_W, requested tone period in clk cycles. 0 means silence.
- volume, input, 2, 0=mute, 1=1/8 duty, 2=1/4 duty, 3=1/2 duty.
- pwm, output, 1, registered buzzer drive.
- active, output, 1, high while a tone (including release) is being generated.
- period_done, output, 1, one-cycle pulse on the last cycle of each generated period.

Behaviour:
- Reset / modechange:
  - On a clk edge with reset==0 or modechange==1: state=IDLE, cnt=0, cur_period=0, pend_period=0, rel_cnt=0.
  - pwm=0, active=0, period_done=0.
  - reset has priority over every other event.
- Input qualification: `req = (frequency >= MIN_PERIOD) ? frequency : 0`, evaluated every cycle.
- States:
  - IDLE: pwm=0, active=0. If req!=0, load cur_period=req and cnt=0, then go to PLAY. pwm first goes high on the cycle after entering PLAY, so latency from frequency valid to the first pwm high is 2 clk edges.
  - PLAY:
    - cnt increments each cycle. When cnt==cur_period-1: period_done=1, cnt wraps to 0, and the boundary decision uses pend_period.
    - pend_period is overwritten by req every cycle; last value before the boundary wins.
    - At the boundary:
      - If pend_period!=0, cur_period=pend_period and stay in PLAY.
      - If pend_period==0 and RELEASE_PERIODS>0, rel_cnt=RELEASE_PERIODS and go to RELEASE.
      - Otherwise go to IDLE.
  - RELEASE:
    - Same counting on cur_period. Duty is forced to level 1 (or 0 if volume==0).
    - At each boundary rel_cnt decrements.
    - If req!=0 at a boundary, load it and return to PLAY (re-trigger). Otherwise, when rel_cnt reaches 0, go to IDLE.
    - A req!=0 arriving mid-period is applied only at the boundary.
- Duty:
  - high_cnt = cur_period>>1 (vol 3), >>2 (vol 2), >>3 (vol 1), 0 (vol 0).
  - pwm_next = (cnt < high_cnt), registered.
  - volume is sampled every cycle; a mid-period change may shorten or lengthen the current high phase, but never produces a pulse narrower than 1 cycle.
  - If high_cnt computes to 0 with volume!=0, pwm stays 0.
- active=1 in PLAY and RELEASE; it follows state with no extra latency.
- Identical consecutive notes produce no boundary glitch: the counter simply continues.
- The counter never exceeds cur_period-1, and cur_period is never changed except at a boundary or on IDLE→PLAY entry.
- No combinational path from any input to pwm.

Test Plan:
1. Reset low 3 cycles with frequency=1000, then release reset → pwm=0, active=0 during reset. active=1 on the first edge after reset deasserts. pwm high for 500 cycles, low for 500, repeating. period_done pulses every 1000 cycles.
2. Playing period 1000, volume 3; frequency switches to 800 at cnt=300 → the first period still completes at 1000 cycles. The next period is 800 (400 high). Exactly one period_done at the switch boundary.
3. frequency=40 (< MIN_PERIOD) from IDLE → pwm stays 0, active stays 0 for 10000 cycles.
4. Period 1000, volume 2, frequency→0 mid-period → the current period finishes with 250 high. Then 4 periods of 125 high each, then IDLE with active=0 and pwm=0.
5. During RELEASE (rel_cnt=2), frequency=600 → at the next boundary, PLAY resumes with period 600 at the requested volume duty.
6. Playing, modechange pulsed 1 cycle at cnt=123 → the next cycle has pwm=0, active=0, cnt=0. With frequency still 1000, the tone restarts from IDLE with 2-cycle latency.
